// File: rtl/fifo_stream_pkg.sv
// Shared types for the async-FIFO read-side drain stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_stream_pkg;

    // Occupancy of the two-entry head/skid buffer.
    typedef enum logic [1:0] {
        RS_EMPTY = 2'd0,
        RS_ONE   = 2'd1,
        RS_TWO   = 2'd2
    } rs_state_t;

    // Width of the optional delivered-word counter.
    localparam int RS_CNT_W = 16;

endpackage

// File: rtl/stream_skid_reg.sv
// Two-entry head/skid buffer: head reg H drives the stream, skid reg S catches one extra word.
// Latency: a pushed word reaches out_dat_o one cycle after push_vld_i (when buffer not full).
// Backpressure: full_o (registered state) tells the producer to stop; pop_rdy_i never reaches full_o.
module stream_skid_reg
    import fifo_stream_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             push_vld_i,
    input  logic [DSIZE-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic             out_vld_o,
    output logic [DSIZE-1:0] out_dat_o,
    output logic             full_o
);

    rs_state_t        state_q;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] skid_q;
    logic             vld_q;
    logic             pop;

    // A pop is only meaningful while the head is valid.
    assign pop = vld_q & pop_rdy_i;

    // Occupancy FSM; S always holds the newer word, H the older one.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= RS_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                RS_EMPTY: begin
                    if (push_vld_i) begin
                        head_q  <= push_dat_i;
                        vld_q   <= 1'b1;
                        state_q <= RS_ONE;
                    end
                end
                RS_ONE: begin
                    if (push_vld_i && !pop) begin
                        skid_q  <= push_dat_i;
                        state_q <= RS_TWO;
                    end else if (pop && !push_vld_i) begin
                        vld_q   <= 1'b0;
                        state_q <= RS_EMPTY;
                    end else if (pop && push_vld_i) begin
                        head_q  <= push_dat_i;
                    end
                end
                RS_TWO: begin
                    // The producer is gated off in TWO, so only a pop can happen.
                    if (pop) begin
                        head_q  <= skid_q;
                        state_q <= RS_ONE;
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    state_q <= RS_EMPTY;
                end
            endcase
        end
    end

    assign out_vld_o = vld_q;
    assign out_dat_o = head_q;
    assign full_o    = (state_q == RS_TWO);

endmodule

// File: rtl/fifo_read_stream.sv
// Drains the async FIFO read port (rempty/rinc/rdata) into a registered valid/ready stream.
// Latency: word popped in cycle k appears on m_data in cycle k+1; full rate with m_ready held high.
// Backpressure: up to 2 words absorbed, then rinc held low; rinc never depends on m_ready.
// Optional build macro RD_STREAM_CNT_EN adds the 16-bit m_count delivered-word counter.
module fifo_read_stream
    import fifo_stream_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    input  logic [DSIZE-1:0]    rdata,
    output logic                rinc,
    output logic                m_valid,
    output logic [DSIZE-1:0]    m_data,
    input  logic                m_ready
`ifdef RD_STREAM_CNT_EN
    ,
    output logic [RS_CNT_W-1:0] m_count
`endif
);

    logic buf_full;

    // Pop the FIFO whenever it has data and the buffer has room; held off during reset.
    assign rinc = rrst_n & ~rempty & ~buf_full;

    stream_skid_reg #(
        .DSIZE (DSIZE)
    ) u_skid (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .push_vld_i (rinc),
        .push_dat_i (rdata),
        .pop_rdy_i  (m_ready),
        .out_vld_o  (m_valid),
        .out_dat_o  (m_data),
        .full_o     (buf_full)
    );

`ifdef RD_STREAM_CNT_EN
    logic [RS_CNT_W-1:0] cnt_q;
    logic [RS_CNT_W-1:0] cnt_d;

    // Count every stream handshake; wraps naturally at the counter width.
    assign cnt_d = (m_valid & m_ready) ? cnt_q + 1'b1 : cnt_q;

    // Delivered-word counter register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign m_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Self-checking bench for fifo_read_stream: FIFO source queue plus in-flight scoreboard.
// Latency: checks outputs 1 time unit after each falling edge.
// Backpressure: random and directed m_ready stalls.
module tb_fifo_read_stream;

    logic       rclk    = 1'b0;
    logic       rrst_n  = 1'b0;
    logic       rempty  = 1'b1;
    logic [7:0] rdata   = 8'h00;
    logic       m_ready = 1'b0;
    logic       rinc;
    logic       m_valid;
    logic [7:0] m_data;
`ifdef RD_STREAM_CNT_EN
    logic [15:0] m_count;
`endif

    fifo_read_stream #(.DSIZE(8)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
`ifdef RD_STREAM_CNT_EN
        ,
        .m_count (m_count)
`endif
    );

    always #5 rclk = ~rclk;

    int checks   = 0;
    int failures = 0;

    // src_q: words still in the FIFO; exp_q: words popped but not yet delivered.
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];
    int         pops_total = 0;
    int         rinc_seen  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then update the model at the rising edge.
    task automatic cycle(input logic rdy, input logic gap);
        logic fire_push;
        logic fire_pop;
        @(negedge rclk);
        rempty  = gap || (src_q.size() == 0);
        rdata   = (src_q.size() != 0) ? src_q[0] : 8'h00;
        m_ready = rdy;
        #1;
        chk("rinc", {31'b0, rinc}, {31'b0, (!rempty && exp_q.size() < 2)});
        chk("m_valid", {31'b0, m_valid}, {31'b0, (exp_q.size() != 0)});
        if (exp_q.size() != 0) chk("m_data", {24'b0, m_data}, {24'b0, exp_q[0]});
        if (prev_stall) chk("stall_stable", {24'b0, m_data}, {24'b0, prev_data});
        fire_push  = rinc;
        fire_pop   = m_valid & m_ready;
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        if (fire_push) rinc_seen++;
        @(posedge rclk);
        if (fire_pop && exp_q.size() != 0) begin
            got_q.push_back(exp_q.pop_front());
            pops_total++;
        end
        if (fire_push && src_q.size() != 0) exp_q.push_back(src_q.pop_front());
    endtask

    task automatic reset_dut();
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        m_ready = 1'b0;
        src_q.delete();
        exp_q.delete();
        got_q.delete();
        ref_q.delete();
        pops_total = 0;
        rinc_seen  = 0;
        prev_stall = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        int bad;

        // 1. Reset with data waiting at the FIFO head.
        rrst_n = 1'b0; rempty = 1'b0; rdata = 8'hA5; m_ready = 1'b0;
        repeat (3) @(posedge rclk);
        @(negedge rclk); #1;
        chk("t1_rst_rinc", {31'b0, rinc}, 32'd0);
        chk("t1_rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t1_rst_m_data", {24'b0, m_data}, 32'd0);
        rrst_n = 1'b1; #1;
        chk("t1_rel_rinc", {31'b0, rinc}, 32'd1);
        @(negedge rclk); #1;
        chk("t1_first_valid", {31'b0, m_valid}, 32'd1);
        chk("t1_first_data", {24'b0, m_data}, 32'h0000_00A5);

        // 2. Sixteen words at full throughput.
        reset_dut();
        for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
        repeat (20) cycle(1'b1, 1'b0);
        chk("t2_rinc_count", rinc_seen, 32'd16);
        chk("t2_delivered", got_q.size(), 32'd16);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i + 1)) bad++;
        chk("t2_order_errs", bad, 32'd0);
`ifdef RD_STREAM_CNT_EN
        chk("t2_m_count", {16'b0, m_count}, 32'd16);
`endif

        // 3. Backpressure: only two words absorbed, then release.
        reset_dut();
        for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
        repeat (6) cycle(1'b0, 1'b0);
        #1;
        chk("t3_stall_rinc_count", rinc_seen, 32'd2);
        chk("t3_stall_valid", {31'b0, m_valid}, 32'd1);
        chk("t3_stall_data", {24'b0, m_data}, 32'h0000_0001);
        repeat (8) cycle(1'b1, 1'b0);
        chk("t3_delivered", got_q.size(), 32'd4);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i + 1)) bad++;
        chk("t3_order_errs", bad, 32'd0);

        // 4. Random ready and random FIFO-empty gaps.
        reset_dut();
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            src_q.push_back(w);
            ref_q.push_back(w);
        end
        for (int c = 0; c < 8000 && (src_q.size() != 0 || exp_q.size() != 0); c++)
            cycle(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
        chk("t4_delivered", got_q.size(), 32'd1000);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) if (got_q[i] !== ref_q[i]) bad++;
        chk("t4_order_errs", bad, 32'd0);

        // 5. Reset while holding two words.
        reset_dut();
        for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h11 + i));
        repeat (4) cycle(1'b0, 1'b0);
        @(negedge rclk); #2;
        rrst_n = 1'b0; #1;
        chk("t5_rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t5_rst_m_data", {24'b0, m_data}, 32'd0);
        chk("t5_rst_rinc", {31'b0, rinc}, 32'd0);
        exp_q.delete();
        got_q.delete();
        prev_stall = 1'b0;
        rempty = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b1;
        repeat (6) cycle(1'b1, 1'b0);
        chk("t5_delivered", got_q.size(), 32'd3);
        chk("t5_first_word", (got_q.size() != 0) ? {24'b0, got_q[0]} : 32'hFFFF_FFFF, 32'h0000_0013);

`ifdef RD_STREAM_CNT_EN
        // 6. Counter wrap after 65537 pops.
        reset_dut();
        for (int i = 0; i < 65537; i++) src_q.push_back(8'(i));
        for (int c = 0; c < 65600 && (src_q.size() != 0 || exp_q.size() != 0); c++)
            cycle(1'b1, 1'b0);
        #1;
        chk("t6_pops", pops_total, 32'd65537);
        chk("t6_m_count_wrap", {16'b0, m_count}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
